// File: rtl/axi_cfg_regfile_fifo.sv
// -----------------------------------------------------------------------------
// axi_cfg_regfile_fifo
//
// AXI4-Lite configuration/status register file for the expansion-ADC path.
// Holds NUM_CFG read/write config words and NUM_STS read-only status words,
// plus a FIFO_DEPTH-deep command FIFO that is filled through the PUSH register
// and drained to the ADC over AXI-Stream (first-word-fall-through).
//
// Word map (word index = addr[ADDR_WIDTH-1:2]):
//   0x00        ID        RO  {8'hCF, NUM_CFG, NUM_STS, log2(FIFO_DEPTH)}
//   0x01        CTRL/STAT RW  rd: [15:0] level, [16] empty, [17] full,
//                                 [24] overflow (sticky)
//                             wr: bit0 flush, bit24 clear overflow
//   0x02        PUSH      WO  write pushes a command; read = last pushed word
//   0x10+k      CFG[k]    RW  byte-lane writes
//   0x20+k      STS[k]    RO  captured at the AR handshake
//   others                    SLVERR, reads return 0
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   cfg                   config word k on bits [32k+31:32k]
//   status                status word k on bits [32k+31:32k]
//   m_axis_*              command stream to the ADC
//   s_axi_aw*/w*/b*       AXI4-Lite write channels (fully decoupled)
//   s_axi_ar*/r*          AXI4-Lite read channels
// -----------------------------------------------------------------------------
module axi_cfg_regfile_fifo #(
    parameter int NUM_CFG    = 4,
    parameter int NUM_STS    = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    aclk,
    input  logic                    areset,

    output logic [32*NUM_CFG-1:0]   cfg,
    input  logic [32*NUM_STS-1:0]   status,

    output logic [31:0]             m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,

    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,

    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,

    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,

    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,

    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int IDX_W = ADDR_WIDTH - 2;

    localparam logic [IDX_W-1:0] IDX_ID   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_CTRL = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_PUSH = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_CFG  = IDX_W'(16);
    localparam logic [IDX_W-1:0] IDX_STS  = IDX_W'(32);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] ID_WORD = {8'hCF, 8'(NUM_CFG), 8'(NUM_STS), 8'(PTR_W)};

    // Byte-lane merge for config writes.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [31:0]      cfg_q [NUM_CFG];
    logic [31:0]      push_q;
    logic             overflow;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop_do;

    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_out
        assign cfg[32*k +: 32] = cfg_q[k];
    end

    assign fifo_full     = (level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty    = (level == '0);
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = mem[rd_ptr];
    assign pop_do        = m_axis_tvalid && m_axis_tready;

    // -------------------------------------------------------------------------
    // Write FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

    wstate_t          wstate;
    wstate_t          wstate_next;
    logic             wr_do;
    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]      w_data_q;
    logic [3:0]       w_strb_q;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;

    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate <= W_IDLE;
        end else begin
            wstate <= wstate_next;
        end
    end

    always_comb begin
        wstate_next = wstate;
        wr_do       = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    wr_do       = 1'b1;
                    wstate_next = W_RESP;
                end else if (s_axi_awvalid) begin
                    wstate_next = W_ADDR;
                end else if (s_axi_wvalid) begin
                    wstate_next = W_DATA;
                end
            end
            W_ADDR: begin
                if (s_axi_wvalid) begin
                    wr_do       = 1'b1;
                    wstate_next = W_RESP;
                end
            end
            W_DATA: begin
                if (s_axi_awvalid) begin
                    wr_do       = 1'b1;
                    wstate_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wstate_next = W_IDLE;
                end
            end
            default: wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = (wstate == W_IDLE) || (wstate == W_DATA);
        s_axi_wready  = (wstate == W_IDLE) || (wstate == W_ADDR);
        s_axi_bvalid  = (wstate == W_RESP);
    end

    // Whichever channel arrived first is held here until its partner shows up.
    always_ff @(posedge aclk) begin
        if (s_axi_awvalid && s_axi_awready) begin
            aw_idx_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
        end
        if (s_axi_wvalid && s_axi_wready) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
        end
    end

    assign wr_idx  = (wstate == W_ADDR) ? aw_idx_q : s_axi_awaddr[ADDR_WIDTH-1:2];
    assign wr_data = (wstate == W_DATA) ? w_data_q : s_axi_wdata;
    assign wr_strb = (wstate == W_DATA) ? w_strb_q : s_axi_wstrb;

    // -------------------------------------------------------------------------
    // Write decode
    // -------------------------------------------------------------------------
    logic [1:0]         wr_resp;
    logic               push_do;
    logic               flush_do;
    logic               ovf_clr;
    logic               ovf_set;
    logic [NUM_CFG-1:0] cfg_we;

    always_comb begin
        wr_resp  = RESP_SLVERR;
        push_do  = 1'b0;
        flush_do = 1'b0;
        ovf_clr  = 1'b0;
        ovf_set  = 1'b0;
        cfg_we   = '0;
        if (wr_idx == IDX_CTRL) begin
            wr_resp  = RESP_OKAY;
            flush_do = wr_do && wr_data[0];
            ovf_clr  = wr_do && wr_data[24];
        end else if (wr_idx == IDX_PUSH) begin
            // Partial-strobe pushes are rejected without touching overflow;
            // a full FIFO drops the word even if a pop happens this cycle.
            if (wr_strb == 4'hF) begin
                if (fifo_full) begin
                    ovf_set = wr_do;
                end else begin
                    wr_resp = RESP_OKAY;
                    push_do = wr_do;
                end
            end
        end else begin
            for (int k = 0; k < NUM_CFG; k++) begin
                if (wr_idx == IDX_CFG + IDX_W'(k)) begin
                    wr_resp   = RESP_OKAY;
                    cfg_we[k] = wr_do;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            s_axi_bresp <= RESP_OKAY;
            overflow    <= 1'b0;
            push_q      <= '0;
            for (int k = 0; k < NUM_CFG; k++) begin
                cfg_q[k] <= '0;
            end
        end else begin
            if (wr_do) begin
                s_axi_bresp <= wr_resp;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (push_do) begin
                push_q <= wr_data;
            end
            for (int k = 0; k < NUM_CFG; k++) begin
                if (cfg_we[k]) begin
                    cfg_q[k] <= merge_bytes(cfg_q[k], wr_data, wr_strb);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Command FIFO
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_do) begin
            // Flush wins over any pop on the same edge.
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_do) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_do) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(push_do) - LVL_W'(pop_do);
        end
    end

    always_ff @(posedge aclk) begin
        if (push_do) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Read FSM
    // -------------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    rstate_t          rstate;
    rstate_t          rstate_next;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_word;
    logic [1:0]       rd_resp;
    logic [31:0]      ctrl_word;

    always_ff @(posedge aclk) begin
        if (areset) begin
            rstate <= R_IDLE;
        end else begin
            rstate <= rstate_next;
        end
    end

    always_comb begin
        rstate_next = rstate;
        case (rstate)
            R_IDLE:  if (s_axi_arvalid) rstate_next = R_DATA;
            R_DATA:  if (s_axi_rready)  rstate_next = R_IDLE;
            default: rstate_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = (rstate == R_IDLE);
        s_axi_rvalid  = (rstate == R_DATA);
    end

    assign rd_idx    = s_axi_araddr[ADDR_WIDTH-1:2];
    assign ctrl_word = {7'd0, overflow, 6'd0, fifo_full, fifo_empty, 16'(level)};

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_SLVERR;
        if (rd_idx == IDX_ID) begin
            rd_word = ID_WORD;
            rd_resp = RESP_OKAY;
        end else if (rd_idx == IDX_CTRL) begin
            rd_word = ctrl_word;
            rd_resp = RESP_OKAY;
        end else if (rd_idx == IDX_PUSH) begin
            rd_word = push_q;
            rd_resp = RESP_OKAY;
        end else begin
            for (int k = 0; k < NUM_CFG; k++) begin
                if (rd_idx == IDX_CFG + IDX_W'(k)) begin
                    rd_word = cfg_q[k];
                    rd_resp = RESP_OKAY;
                end
            end
            for (int k = 0; k < NUM_STS; k++) begin
                if (rd_idx == IDX_STS + IDX_W'(k)) begin
                    rd_word = status[32*k +: 32];
                    rd_resp = RESP_OKAY;
                end
            end
        end
    end

    // Read data is captured at the AR handshake and held until R completes.
    always_ff @(posedge aclk) begin
        if (areset) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rdata <= rd_word;
            s_axi_rresp <= rd_resp;
        end
    end

endmodule
